// File: rtl/bomberman_copy_engine_if.sv
// Copy-engine bus: controller strobes in, ROM port and
// frame-buffer write port out.
interface bomberman_copy_engine_if #(
   parameter int COLOUR_W = 3
);
   logic                copy_enable;
   logic [1:0]          memory_select;
   logic                full_screen;
   logic [7:0]          base_x;
   logic [6:0]          base_y;
   logic [3:0]          sprite_index;
   logic                black;
   logic                transparent_en;
   logic [1:0]          rom_sel;
   logic [14:0]         rom_addr;
   logic [COLOUR_W-1:0] rom_data;
   logic [7:0]          buf_x;
   logic [6:0]          buf_y;
   logic [COLOUR_W-1:0] buf_colour;
   logic                buf_we;
   logic                busy;
   logic                finished;

   modport master (
      output copy_enable, memory_select, full_screen,
      output base_x, base_y, sprite_index,
      output black, transparent_en, rom_data,
      input  rom_sel, rom_addr, buf_x, buf_y,
      input  buf_colour, buf_we, busy, finished
   );

   modport slave (
      input  copy_enable, memory_select, full_screen,
      input  base_x, base_y, sprite_index,
      input  black, transparent_en, rom_data,
      output rom_sel, rom_addr, buf_x, buf_y,
      output buf_colour, buf_we, busy, finished
   );
endinterface

// File: rtl/bomberman_copy_engine.sv
// Pixel copy engine: walks background or one sprite tile,
// reads the image ROM and writes the frame buffer.
module bomberman_copy_engine #(
   parameter int SCREEN_W = 160,
   parameter int SCREEN_H = 120,
   parameter int TILE     = 16,
   parameter int COLOUR_W = 3,
   parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
) (
   input logic clock,
   input logic reset,
   bomberman_copy_engine_if.slave bus
);
   localparam int TB = $clog2(TILE);

   typedef enum logic [1:0] {
      IDLE, RUN, FLUSH, DONE
   } state_t;

   state_t state, state_nx;

   logic [7:0] cx;
   logic [6:0] cy;
   logic       full_l;
   logic       trans_l;
   logic [1:0] sel_l;
   logic [7:0] bx_l;
   logic [6:0] by_l;
   logic [3:0] idx_l;

   logic       wr_valid;
   logic       wr_clip;
   logic [7:0] wr_x;
   logic [6:0] wr_y;

   logic       start;
   logic       last_px;
   logic [7:0] w_max;
   logic [6:0] h_max;
   logic [8:0] dst_x;
   logic [7:0] dst_y;
   logic       dst_clip;
   logic [14:0] addr_full;
   logic [14:0] addr_tile;
   logic [4+2*TB-1:0] tile_cat;
   logic       wr_live;
   logic       skip;

   assign start = (state == IDLE) && bus.copy_enable;
   assign w_max = full_l ? 8'(SCREEN_W-1) : 8'(TILE-1);
   assign h_max = full_l ? 7'(SCREEN_H-1) : 7'(TILE-1);
   assign last_px = (cx == w_max) && (cy == h_max);

   assign dst_x = {1'b0, bx_l} + {1'b0, cx};
   assign dst_y = {1'b0, by_l} + {1'b0, cy};
   assign dst_clip = (dst_x >= 9'(SCREEN_W))
                  || (dst_y >= 8'(SCREEN_H));

   assign addr_full = 15'(cy) * 15'(SCREEN_W) + 15'(cx);
   assign tile_cat  = {idx_l, cy[TB-1:0], cx[TB-1:0]};
   assign addr_tile = 15'(tile_cat);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (bus.copy_enable) state_nx = RUN;
         RUN: begin
            if (!bus.copy_enable) state_nx = IDLE;
            else if (last_px)     state_nx = FLUSH;
         end
         FLUSH: state_nx = bus.copy_enable ? DONE : IDLE;
         DONE:  state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cx      <= '0;
         cy      <= '0;
         full_l  <= 1'b0;
         trans_l <= 1'b0;
         sel_l   <= '0;
         bx_l    <= '0;
         by_l    <= '0;
         idx_l   <= '0;
      end else if (start) begin
         cx      <= '0;
         cy      <= '0;
         full_l  <= bus.full_screen;
         trans_l <= bus.transparent_en;
         sel_l   <= bus.memory_select;
         bx_l    <= bus.base_x;
         by_l    <= bus.base_y;
         idx_l   <= bus.sprite_index;
      end else if (state == RUN) begin
         if (cx == w_max) begin
            cx <= '0;
            cy <= cy + 7'd1;
         end else begin
            cx <= cx + 8'd1;
         end
      end
   end

   // Destination of the pixel addressed this cycle; its ROM
   // data arrives next cycle, when the write is issued.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_valid <= 1'b0;
         wr_clip  <= 1'b0;
         wr_x     <= '0;
         wr_y     <= '0;
      end else begin
         wr_valid <= (state == RUN) && bus.copy_enable;
         wr_clip  <= !full_l && dst_clip;
         wr_x     <= full_l ? cx : dst_x[7:0];
         wr_y     <= full_l ? cy : dst_y[6:0];
      end
   end

   assign wr_live = wr_valid && bus.copy_enable;
   assign skip = trans_l && !bus.black
              && (bus.rom_data == TRANSPARENT);

   assign bus.rom_addr = (state != RUN) ? '0
                       : full_l ? addr_full : addr_tile;
   assign bus.rom_sel    = sel_l;
   assign bus.buf_x      = wr_x;
   assign bus.buf_y      = wr_y;
   assign bus.buf_we     = wr_live && !skip && !wr_clip;
   assign bus.buf_colour = (wr_live && !bus.black)
                         ? bus.rom_data : '0;
   assign bus.busy       = (state != IDLE);
   assign bus.finished   = (state == DONE);
endmodule

// File: tb/tb_bomberman_copy_engine.sv
// Directed bench for the copy engine with a ROM model and
// a write monitor that predicts every written colour.
module tb_bomberman_copy_engine;
   logic clock = 1'b0;
   logic reset = 1'b1;

   bomberman_copy_engine_if #(.COLOUR_W(3)) bus ();

   bomberman_copy_engine dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int rom_mode = 0;

   int wcount, fin_count, fin_cyc, col_err, last_col;
   int minx, maxx, miny, maxy, amin, amax;
   int start, lat, w0, f0, f1, fc;
   bit chk_col = 1'b1;
   bit cfg_full;
   int cfg_bx, cfg_by, cfg_idx;

   function automatic logic [2:0] rom_f(input logic [14:0] a);
      if (rom_mode == 1) return a[0] ? 3'b011 : 3'b101;
      return a[2:0];
   endfunction

   always @(posedge clock) cyc <= cyc + 1;
   always @(posedge clock) bus.rom_data <= rom_f(bus.rom_addr);

   always @(negedge clock) begin : mon
      int x, y, a;
      logic [2:0] e;
      if (bus.buf_we === 1'b1) begin
         wcount++;
         x = int'(bus.buf_x);
         y = int'(bus.buf_y);
         if (x < minx) minx = x;
         if (x > maxx) maxx = x;
         if (y < miny) miny = y;
         if (y > maxy) maxy = y;
         if (x == 159 && y == 119) last_col = int'(bus.buf_colour);
         if (chk_col) begin
            a = cfg_full ? y*160 + x
              : cfg_idx*256 + (y-cfg_by)*16 + (x-cfg_bx);
            e = bus.black ? 3'b000 : rom_f(15'(a));
            if (bus.buf_colour !== e) col_err++;
         end
      end
      if (bus.rom_addr != 15'd0) begin
         if (int'(bus.rom_addr) < amin) amin = int'(bus.rom_addr);
         if (int'(bus.rom_addr) > amax) amax = int'(bus.rom_addr);
      end
      if (bus.finished === 1'b1) begin
         fin_count++;
         fin_cyc = cyc;
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr();
      wcount = 0; col_err = 0; last_col = -1;
      minx = 9999; maxx = -1; miny = 9999; maxy = -1;
      amin = 99999; amax = -1;
   endtask

   task automatic start_copy(input bit full, input logic [1:0] sel,
                             input int bx, input int by,
                             input int idx, input bit tr,
                             input bit blk);
      step();
      bus.full_screen    = full;
      bus.memory_select  = sel;
      bus.base_x         = 8'(bx);
      bus.base_y         = 7'(by);
      bus.sprite_index   = 4'(idx);
      bus.transparent_en = tr;
      bus.black          = blk;
      bus.copy_enable    = 1'b1;
      cfg_full = full; cfg_bx = bx; cfg_by = by; cfg_idx = idx;
      clr();
      start = cyc;
   endtask

   task automatic wait_fin(input int budget, output int c);
      int f;
      f = fin_count;
      c = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (fin_count > f) begin
            c = fin_cyc;
            break;
         end
      end
      if (c < 0) chk("finish_timeout", 0, 1);
   endtask

   task automatic end_copy();
      bus.copy_enable = 1'b0;
      @(negedge clock);
      chk("fin_width", bus.finished, 0);
   endtask

   initial begin
      bus.copy_enable = 0; bus.memory_select = 0;
      bus.full_screen = 0; bus.base_x = 0; bus.base_y = 0;
      bus.sprite_index = 0; bus.black = 0; bus.transparent_en = 0;
      fin_count = 0; fin_cyc = 0;
      clr();
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_fin", bus.finished, 0);
      chk("rst_we", bus.buf_we, 0);
      chk("rst_addr", bus.rom_addr, 0);
      chk("rst_x", bus.buf_x, 0);
      chk("rst_y", bus.buf_y, 0);
      chk("rst_col", bus.buf_colour, 0);
      chk("rst_sel", bus.rom_sel, 0);
      step(); step();
      reset = 1'b0;
      step();

      start_copy(1, 2'd1, 0, 0, 0, 0, 0);
      wait_fin(20000, fc);
      end_copy();
      chk("full_lat", fc - start, 19202);
      chk("full_writes", wcount, 19200);
      chk("full_last_col", last_col, 7);
      chk("full_sel", bus.rom_sel, 1);
      chk("full_col", col_err, 0);

      start_copy(0, 2'd3, 32, 48, 3, 0, 0);
      wait_fin(400, fc);
      end_copy();
      chk("tile_lat", fc - start, 258);
      chk("tile_writes", wcount, 256);
      chk("tile_minx", minx, 32);
      chk("tile_maxx", maxx, 47);
      chk("tile_miny", miny, 48);
      chk("tile_maxy", maxy, 63);
      chk("tile_amin", amin, 768);
      chk("tile_amax", amax, 1023);
      chk("tile_col", col_err, 0);

      rom_mode = 1;
      start_copy(0, 2'd3, 0, 0, 2, 1, 0);
      wait_fin(400, fc);
      end_copy();
      chk("trans_writes", wcount, 128);
      chk("trans_col", col_err, 0);
      start_copy(0, 2'd3, 0, 0, 2, 1, 1);
      wait_fin(400, fc);
      end_copy();
      chk("black_writes", wcount, 256);
      chk("black_col", col_err, 0);
      rom_mode = 0;

      start_copy(0, 2'd3, 152, 112, 1, 0, 0);
      wait_fin(400, fc);
      end_copy();
      chk("clip_lat", fc - start, 258);
      chk("clip_writes", wcount, 64);
      chk("clip_minx", minx, 152);
      chk("clip_maxx", maxx, 159);
      chk("clip_maxy", maxy, 119);
      chk("clip_col", col_err, 0);

      f0 = fin_count;
      start_copy(0, 2'd3, 0, 0, 5, 0, 0);
      chk_col = 1'b0;
      step();
      bus.full_screen = 1'b1;
      bus.memory_select = 2'd2;
      wait_fin(400, f1);
      chk("b2b_lat1", f1 - start, 258);
      wait_fin(20000, fc);
      end_copy();
      chk("b2b_lat2", fc - f1, 19203);
      chk("b2b_fins", fin_count - f0, 2);
      chk("b2b_writes", wcount, 256 + 19200);
      chk("b2b_sel", bus.rom_sel, 2);
      chk_col = 1'b1;

      start_copy(1, 2'd0, 0, 0, 0, 0, 0);
      while (cyc < start + 100) step();
      bus.copy_enable = 1'b0;
      w0 = wcount;
      f0 = fin_count;
      chk("abort_pre", w0, 98);
      step();
      @(negedge clock);
      chk("abort_busy", bus.busy, 0);
      repeat (30) step();
      chk("abort_writes", wcount, w0);
      chk("abort_fin", fin_count, f0);

      start_copy(1, 2'd2, 0, 0, 0, 0, 0);
      while (cyc < start + 100) step();
      reset = 1'b1;
      w0 = wcount;
      f0 = fin_count;
      #1;
      chk("rstab_busy", bus.busy, 0);
      chk("rstab_we", bus.buf_we, 0);
      repeat (3) step();
      bus.copy_enable = 1'b0;
      reset = 1'b0;
      repeat (30) step();
      chk("rstab_writes", wcount, w0);
      chk("rstab_fin", fin_count, f0);
      chk("rstab_idle", bus.busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
